// File: rtl/i2c_reg_bridge.sv
// Byte-stream to 16-bit register bus bridge behind an I2C slave front end.
// Writes: pointer byte then MSB/LSB pairs; reads: two tx bytes per register word.
module i2c_reg_bridge #(
    parameter bit AUTO_INC = 1'b1
) (
    input  logic        clk_reg_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        rw_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_req_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic [7:0]  addr_o,
    output logic [15:0] wdata_o,
    output logic        wr_en_o,
    output logic        rd_en_o,
    input  logic [15:0] rdata_i
);

    localparam int unsigned BW = 8;
    localparam int unsigned WW = 16;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_MSB, GET_LSB, RD_MSB, RD_LSB
    } state_e;

    typedef enum logic [1:0] {
        TX_FF, TX_MSB, TX_LSB
    } tx_kind_e;

    state_e        state_q, state_d;
    tx_kind_e      kind_q, kind_d;
    logic          pend_q, pend_d;
    logic [BW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] msb_q, msb_d;
    logic [BW-1:0] shadow_q, shadow_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [WW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic [BW-1:0] ptr_inc;

    assign ptr_inc = AUTO_INC ? BW'(ptr_q + BW'(1)) : ptr_q;

    always_ff @(posedge clk_reg_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            kind_q     <= TX_FF;
            pend_q     <= 1'b0;
            ptr_q      <= '0;
            msb_q      <= '0;
            shadow_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            msb_q      <= msb_d;
            shadow_q   <= shadow_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // Bus events win over data; pend_q carries a tx request into its second cycle.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        pend_d     = 1'b0;
        ptr_d      = ptr_q;
        msb_d      = msb_q;
        shadow_d   = shadow_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;

        if (start_i) begin
            state_d = rw_i ? RD_MSB : GET_ADDR;
        end else if (stop_i) begin
            state_d = IDLE;
        end else begin
            if (pend_q) begin
                tx_valid_d = 1'b1;
                unique case (kind_q)
                    TX_MSB: begin
                        tx_data_d = rdata_i[WW-1:BW];
                        shadow_d  = rdata_i[BW-1:0];
                        state_d   = RD_LSB;
                    end
                    TX_LSB: begin
                        tx_data_d = shadow_q;
                        ptr_d     = ptr_inc;
                        state_d   = RD_MSB;
                    end
                    default: tx_data_d = 8'hFF;
                endcase
            end

            if (tx_req_i) begin
                pend_d = 1'b1;
                unique case (state_q)
                    RD_MSB: begin
                        kind_d  = TX_MSB;
                        rd_en_d = 1'b1;
                        addr_d  = ptr_q;
                    end
                    RD_LSB:  kind_d = TX_LSB;
                    default: kind_d = TX_FF;
                endcase
            end

            if (rx_valid_i) begin
                unique case (state_q)
                    GET_ADDR: begin
                        ptr_d   = rx_data_i;
                        state_d = GET_MSB;
                    end
                    GET_MSB: begin
                        msb_d   = rx_data_i;
                        state_d = GET_LSB;
                    end
                    GET_LSB: begin
                        wr_en_d = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = {msb_q, rx_data_i};
                        ptr_d   = ptr_inc;
                        state_d = GET_MSB;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign wr_en_o    = wr_en_q;
    assign rd_en_o    = rd_en_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed bench for i2c_reg_bridge: write, read, wrap, abort, collision and reset cases.
// A second instance with AUTO_INC=0 shares the inputs for the non-incrementing checks.
module tb_i2c_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, rw, rx_valid, tx_req;
    logic [7:0]  rx_data;
    logic [15:0] rdata;

    logic [7:0]  tx_data, addr;
    logic [15:0] wdata;
    logic        tx_valid, wr_en, rd_en;

    logic [7:0]  ni_tx_data, ni_addr;
    logic [15:0] ni_wdata;
    logic        ni_tx_valid, ni_wr_en, ni_rd_en;

    always #5 clk = ~clk;

    i2c_reg_bridge #(.AUTO_INC(1'b1)) dut (
        .clk_reg_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .rw_i(rw),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .tx_req_i(tx_req),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .addr_o(addr), .wdata_o(wdata),
        .wr_en_o(wr_en), .rd_en_o(rd_en), .rdata_i(rdata)
    );

    i2c_reg_bridge #(.AUTO_INC(1'b0)) dut_ni (
        .clk_reg_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .rw_i(rw),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .tx_req_i(tx_req),
        .tx_data_o(ni_tx_data), .tx_valid_o(ni_tx_valid), .addr_o(ni_addr), .wdata_o(ni_wdata),
        .wr_en_o(ni_wr_en), .rd_en_o(ni_rd_en), .rdata_i(rdata)
    );

    // Register file seen by the read path.
    always_comb begin
        case (addr)
            8'h20:   rdata = 16'hBEEF;
            8'h21:   rdata = 16'hCAFE;
            default: rdata = 16'h0000;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0]  wr_a[64];
    logic [15:0] wr_d[64];
    logic [7:0]  ni_wr_a[64];
    logic [15:0] ni_wr_d[64];
    logic [7:0]  rd_a[64];
    logic [7:0]  tx_b[64];
    int          tx_c[64];
    int          wr_n = 0, ni_wr_n = 0, rd_n = 0, tx_n = 0, both_n = 0;

    // Logs strobes just after each falling edge, clear of the stimulus process.
    always @(negedge clk) begin
        #1;
        if (wr_en && wr_n < 64) begin
            wr_a[wr_n] = addr; wr_d[wr_n] = wdata; wr_n++;
        end
        if (ni_wr_en && ni_wr_n < 64) begin
            ni_wr_a[ni_wr_n] = ni_addr; ni_wr_d[ni_wr_n] = ni_wdata; ni_wr_n++;
        end
        if (rd_en && rd_n < 64) begin
            rd_a[rd_n] = addr; rd_n++;
        end
        if (tx_valid && tx_n < 64) begin
            tx_b[tx_n] = tx_data; tx_c[tx_n] = cyc; tx_n++;
        end
        if ((wr_en && rd_en) || (ni_wr_en && ni_rd_en)) both_n++;
    end

    int req_c[64];
    int req_n = 0;

    task automatic pulse(input bit st, input bit sp, input bit r, input bit rxv,
                         input logic [7:0] d, input bit txr);
        start = st; stop = sp; rw = r; rx_valid = rxv; rx_data = d; tx_req = txr;
        if (txr && req_n < 64) begin
            req_c[req_n] = cyc; req_n++;
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; rw = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0;
    endtask

    task automatic sstart(input bit r);        pulse(1'b1, 1'b0, r, 1'b0, 8'h00, 1'b0); endtask
    task automatic sstop();                    pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
    task automatic wbyte(input logic [7:0] d); pulse(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0); endtask
    task automatic treq();                     pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask
    task automatic idle(input int n);          repeat (n) @(negedge clk); endtask

    initial begin
        int wb, nb, rb, tb, qb;
        logic [7:0] exp_rd[4];
        exp_rd = '{8'hBE, 8'hEF, 8'hCA, 8'hFE};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; rw = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0;
        idle(3);
        check("rst_strobes", 32'({tx_valid, wr_en, rd_en}), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("ni_rst_strobes", 32'({ni_tx_valid, ni_wr_en, ni_rd_en}), 0);
        check("ni_rst_data", 32'({ni_addr, ni_wdata, ni_tx_data}), 0);
        rst_n = 1'b1;
        idle(2);

        // Two-word burst write
        wb = wr_n; nb = ni_wr_n;
        sstart(1'b0);
        wbyte(8'h10); wbyte(8'hAB); wbyte(8'hCD); wbyte(8'h12); wbyte(8'h34);
        sstop(); idle(3);
        check("wr_count", 32'(wr_n - wb), 2);
        check("wr0_addr", 32'(wr_a[wb]), 'h10);
        check("wr0_data", 32'(wr_d[wb]), 'hABCD);
        check("wr1_addr", 32'(wr_a[wb+1]), 'h11);
        check("wr1_data", 32'(wr_d[wb+1]), 'h1234);
        check("addr_hold", 32'(addr), 'h11);
        check("wdata_hold", 32'(wdata), 'h1234);
        check("ni_wr1_addr", 32'(ni_wr_a[nb+1]), 'h10);
        check("ni_wr1_data", 32'(ni_wr_d[nb+1]), 'h1234);

        // Register read after repeated START
        tb = tx_n; rb = rd_n; qb = req_n;
        sstart(1'b0); wbyte(8'h20); sstart(1'b1);
        for (int i = 0; i < 4; i++) begin
            treq(); idle(4);
        end
        check("rd_tx_count", 32'(tx_n - tb), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_byte%0d", i), 32'(tx_b[tb+i]), 32'(exp_rd[i]));
            check($sformatf("rd_lat%0d", i), 32'(tx_c[tb+i] - req_c[qb+i]), 2);
        end
        check("rd_en_count", 32'(rd_n - rb), 2);
        check("rd0_addr", 32'(rd_a[rb]), 'h20);
        check("rd1_addr", 32'(rd_a[rb+1]), 'h21);
        sstop(); idle(2);

        // Pointer wrap at 0xFF
        wb = wr_n; nb = ni_wr_n;
        sstart(1'b0);
        wbyte(8'hFF); wbyte(8'hAB); wbyte(8'hCD); wbyte(8'h12); wbyte(8'h34);
        sstop(); idle(3);
        check("wrap_count", 32'(wr_n - wb), 2);
        check("wrap0_addr", 32'(wr_a[wb]), 'hFF);
        check("wrap1_addr", 32'(wr_a[wb+1]), 'h00);
        check("ni_wrap0_addr", 32'(ni_wr_a[nb]), 'hFF);
        check("ni_wrap1_addr", 32'(ni_wr_a[nb+1]), 'hFF);

        // Half word discarded by STOP; read request outside a read phase
        wb = wr_n;
        sstart(1'b0); wbyte(8'h05); wbyte(8'h77); sstop(); idle(3);
        check("abort_no_wr", 32'(wr_n - wb), 0);
        tb = tx_n; qb = req_n;
        sstart(1'b0); wbyte(8'h05); treq(); idle(4);
        check("ff_count", 32'(tx_n - tb), 1);
        check("ff_byte", 32'(tx_b[tb]), 'hFF);
        check("ff_lat", 32'(tx_c[tb] - req_c[qb]), 2);
        sstop(); idle(2);

        // START colliding with the LSB byte drops it
        wb = wr_n;
        sstart(1'b0); wbyte(8'h40); wbyte(8'hAA);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0);
        wbyte(8'h50); wbyte(8'h11); wbyte(8'h22);
        sstop(); idle(3);
        check("coll_count", 32'(wr_n - wb), 1);
        check("coll_addr", 32'(wr_a[wb]), 'h50);
        check("coll_data", 32'(wr_d[wb]), 'h1122);

        // STOP together with START behaves as START
        wb = wr_n;
        sstart(1'b0); wbyte(8'h70); wbyte(8'h01);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        wbyte(8'h60); wbyte(8'h01); wbyte(8'h02);
        sstop(); idle(3);
        check("ss_count", 32'(wr_n - wb), 1);
        check("ss_addr", 32'(wr_a[wb]), 'h60);
        check("ss_data", 32'(wr_d[wb]), 'h0102);

        // Reset between a read request and its response
        sstart(1'b0); wbyte(8'h20); sstart(1'b1);
        tb = tx_n;
        treq();
        check("rd_before_rst", 32'(rd_en), 1);
        rst_n = 1'b0;
        idle(3);
        check("rst_no_tx", 32'(tx_n - tb), 0);
        check("rst2_strobes", 32'({tx_valid, wr_en, rd_en}), 0);
        check("rst2_data", 32'({addr, wdata, tx_data}), 0);
        rst_n = 1'b1;
        idle(2);

        check("strobe_exclusive", 32'(both_n), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
